// File: rtl/soc_axil_master_bridge_if.sv
`timescale 1ns/1ps
// AXI-Lite bundle between the native-request bridge (master) and the crossbar slave port.
interface soc_axil_master_bridge_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic                    awvalid, awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wvalid, wready;
   logic [1:0]              bresp;
   logic                    bvalid, bready;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic                    arvalid, arready;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rvalid, rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );
endinterface

// File: rtl/soc_axil_master_bridge.sv
`timescale 1ns/1ps
// Single-outstanding native request -> AXI-Lite master, with local misalign rejection
// and a per-transaction timeout that drains the hung handshake before going idle.
module soc_axil_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_we,
   input  logic [ADDR_WIDTH-1:0]   req_addr,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   output logic                    rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic                    rsp_timeout,
   output logic                    rsp_misalign,
   output logic                    busy,
   soc_axil_master_bridge_if.master m_axi
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;
   localparam logic [2:0] DRAIN   = 3'd5;
   localparam logic [16:0] TMO_LIM = 17'(TIMEOUT_CYCLES);

   logic [2:0]              state_q, state_d;
   logic [15:0]             cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_rdata_q, rsp_rdata_d;
   logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
   logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
   logic bready_q, bready_d, rready_q, rready_d;
   logic rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d, rsp_misalign_q, rsp_misalign_d;
   logic [1:0] rsp_resp_q, rsp_resp_d;
   logic aw_hs, w_hs, ar_hs, b_hs, r_hs, tmo_hit, tmo_fire;

   assign aw_hs = awvalid_q & m_axi.awready;
   assign w_hs  = wvalid_q  & m_axi.wready;
   assign ar_hs = arvalid_q & m_axi.arready;
   assign b_hs  = bready_q  & m_axi.bvalid;
   assign r_hs  = rready_q  & m_axi.rvalid;
   // cnt_q is 0 in the first cycle after acceptance, so the error pulse lands
   // TIMEOUT_CYCLES cycles after acceptance, same reference as the normal latency.
   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (({1'b0, cnt_q} + 17'd2) >= TMO_LIM);

   always_comb begin
      state_d        = state_q;
      cnt_d          = (state_q == IDLE) ? '0 : cnt_q + 16'd1;
      awaddr_d       = awaddr_q;
      araddr_d       = araddr_q;
      wdata_d        = wdata_q;
      wstrb_d        = wstrb_q;
      awvalid_d      = awvalid_q & ~aw_hs;
      wvalid_d       = wvalid_q  & ~w_hs;
      arvalid_d      = arvalid_q & ~ar_hs;
      bready_d       = bready_q;
      rready_d       = rready_q;
      rsp_valid_d    = 1'b0;
      rsp_rdata_d    = '0;
      rsp_resp_d     = 2'b00;
      rsp_timeout_d  = 1'b0;
      rsp_misalign_d = 1'b0;
      tmo_fire       = 1'b0;
      case (state_q)
         IDLE: if (req_valid) begin
            if (req_addr[1:0] != 2'b00) begin
               rsp_valid_d    = 1'b1;
               rsp_resp_d     = 2'b10;
               rsp_misalign_d = 1'b1;
            end else if (req_we) begin
               awaddr_d  = req_addr;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               state_d   = WR_REQ;
            end else begin
               araddr_d  = req_addr;
               arvalid_d = 1'b1;
               state_d   = RD_REQ;
            end
         end
         WR_REQ: if (!awvalid_d && !wvalid_d) begin
            state_d  = WR_RESP;
            bready_d = 1'b1;
         end else tmo_fire = tmo_hit;
         WR_RESP: if (b_hs) begin
            rsp_valid_d = 1'b1;
            rsp_resp_d  = m_axi.bresp;
            bready_d    = 1'b0;
            state_d     = IDLE;
         end else tmo_fire = tmo_hit;
         RD_REQ: if (!arvalid_d) begin
            state_d  = RD_RESP;
            rready_d = 1'b1;
         end else tmo_fire = tmo_hit;
         RD_RESP: if (r_hs) begin
            rsp_valid_d = 1'b1;
            rsp_resp_d  = m_axi.rresp;
            rsp_rdata_d = (m_axi.rresp == 2'b00) ? m_axi.rdata : '0;
            rready_d    = 1'b0;
            state_d     = IDLE;
         end else tmo_fire = tmo_hit;
         // B/R cannot precede the request handshakes, so either one ends the drain
         DRAIN: if (b_hs || r_hs) begin
            bready_d = 1'b0;
            rready_d = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (tmo_fire) begin
         rsp_valid_d   = 1'b1;
         rsp_resp_d    = 2'b10;
         rsp_timeout_d = 1'b1;
         bready_d      = 1'b1;
         rready_d      = 1'b1;
         state_d       = DRAIN;
      end
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         awaddr_q       <= '0;
         araddr_q       <= '0;
         wdata_q        <= '0;
         wstrb_q        <= '0;
         awvalid_q      <= 1'b0;
         wvalid_q       <= 1'b0;
         arvalid_q      <= 1'b0;
         bready_q       <= 1'b0;
         rready_q       <= 1'b0;
         rsp_valid_q    <= 1'b0;
         rsp_rdata_q    <= '0;
         rsp_resp_q     <= 2'b00;
         rsp_timeout_q  <= 1'b0;
         rsp_misalign_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         awaddr_q       <= awaddr_d;
         araddr_q       <= araddr_d;
         wdata_q        <= wdata_d;
         wstrb_q        <= wstrb_d;
         awvalid_q      <= awvalid_d;
         wvalid_q       <= wvalid_d;
         arvalid_q      <= arvalid_d;
         bready_q       <= bready_d;
         rready_q       <= rready_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_resp_q     <= rsp_resp_d;
         rsp_timeout_q  <= rsp_timeout_d;
         rsp_misalign_q <= rsp_misalign_d;
      end
   end

   assign req_ready     = (state_q == IDLE) && !areset;
   assign busy          = (state_q != IDLE);
   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign rsp_misalign  = rsp_misalign_q;
   assign m_axi.awaddr  = awaddr_q;
   assign m_axi.awvalid = awvalid_q;
   assign m_axi.wdata   = wdata_q;
   assign m_axi.wstrb   = wstrb_q;
   assign m_axi.wvalid  = wvalid_q;
   assign m_axi.bready  = bready_q;
   assign m_axi.araddr  = araddr_q;
   assign m_axi.arvalid = arvalid_q;
   assign m_axi.rready  = rready_q;
endmodule
